// File: rtl/ddr_host_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : ddr_host_cmd_issuer
// Description : Host-side command sequencer for a DDR controller. After reset
//               it waits INIT_WAIT cycles, runs the PRECHARGE / LOAD_REG2 /
//               LOAD_REG1 / LOAD_MODE init sequence, then serves single-burst
//               user reads and writes. Periodic refreshes take priority over
//               user requests. Every controller command is held until CMDACK,
//               and a missing CMDACK is bounded by ACK_TIMEOUT.
// Ports       : CLK, RESET_N            clock, async active-low reset
//               req_*                   user request handshake and address
//               wd_req/wd_data/wd_mask  write-beat pull interface
//               rd_valid/rd_data        registered read beats
//               ADDR/CMD/CMDACK         controller command channel
//               DATAIN/DM/DATAOUT       controller data channel
//               init_done/busy/err_timeout  status
// Revision    : 1.0  initial release
// ============================================================================
module ddr_host_cmd_issuer #(
  parameter int               ASIZE       = 23,
  parameter int               DSIZE       = 128,
  parameter int               BEATS       = 2,
  parameter int               RD_LAT      = 4,
  parameter int               INIT_WAIT   = 200,
  parameter int               REF_PERIOD  = 1560,
  parameter int               ACK_TIMEOUT = 64,
  parameter logic [ASIZE-1:0] MODE_WORD   = '0,
  parameter logic [ASIZE-1:0] REG1_WORD   = '0,
  parameter logic [ASIZE-1:0] REG2_WORD   = '0
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ASIZE-1:0]   req_addr,
  output logic               wd_req,
  input  logic [DSIZE-1:0]   wd_data,
  input  logic [DSIZE/8-1:0] wd_mask,
  output logic               rd_valid,
  output logic [DSIZE-1:0]   rd_data,
  output logic [ASIZE-1:0]   ADDR,
  output logic [2:0]         CMD,
  input  logic               CMDACK,
  output logic [DSIZE-1:0]   DATAIN,
  output logic [DSIZE/8-1:0] DM,
  input  logic [DSIZE-1:0]   DATAOUT,
  output logic               init_done,
  output logic               busy,
  output logic               err_timeout
);

  localparam int CW = $clog2(INIT_WAIT + ACK_TIMEOUT + RD_LAT + BEATS + 1) + 1;
  localparam int RW = $clog2(REF_PERIOD + 1);

  localparam logic [2:0] c_CMD_NOP   = 3'b000;
  localparam logic [2:0] c_CMD_READA = 3'b001;
  localparam logic [2:0] c_CMD_WRITA = 3'b010;
  localparam logic [2:0] c_CMD_REF   = 3'b011;
  localparam logic [2:0] c_CMD_PRE   = 3'b100;
  localparam logic [2:0] c_CMD_MODE  = 3'b101;
  localparam logic [2:0] c_CMD_REG1  = 3'b110;
  localparam logic [2:0] c_CMD_REG2  = 3'b111;

  typedef enum logic [3:0] {
    S_WAIT_INIT = 4'd0,
    S_I_PRE     = 4'd1,
    S_I_REG2    = 4'd2,
    S_I_REG1    = 4'd3,
    S_I_MODE    = 4'd4,
    S_IDLE      = 4'd5,
    S_REF       = 4'd6,
    S_RD_CMD    = 4'd7,
    S_RD_WAIT   = 4'd8,
    S_RD_DATA   = 4'd9,
    S_WR_CMD    = 4'd10,
    S_WR_DATA   = 4'd11
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt;
  logic               r_gap, w_gap_nxt;
  logic [RW-1:0]      r_ref_cnt;
  logic               r_ref_pending;
  logic               r_init_done;
  logic               r_err;
  logic [ASIZE-1:0]   r_addr;
  logic               r_rd_valid;
  logic [DSIZE-1:0]   r_rd_data;

  logic [2:0]         w_state_cmd;
  logic [ASIZE-1:0]   w_state_addr;
  logic               w_issuing;
  logic               w_ack;
  logic               w_timeout;
  logic               w_req_ready;
  logic               w_accept;
  logic               w_ref_wrap;

  // Command and address implied by the current state.
  always_comb begin
    w_state_cmd  = c_CMD_NOP;
    w_state_addr = '0;
    case (r_state)
      S_I_PRE:  w_state_cmd = c_CMD_PRE;
      S_I_REG2: begin w_state_cmd = c_CMD_REG2;  w_state_addr = REG2_WORD; end
      S_I_REG1: begin w_state_cmd = c_CMD_REG1;  w_state_addr = REG1_WORD; end
      S_I_MODE: begin w_state_cmd = c_CMD_MODE;  w_state_addr = MODE_WORD; end
      S_REF:    w_state_cmd = c_CMD_REF;
      S_RD_CMD: begin w_state_cmd = c_CMD_READA; w_state_addr = r_addr; end
      S_WR_CMD: begin w_state_cmd = c_CMD_WRITA; w_state_addr = r_addr; end
      default:  w_state_cmd = c_CMD_NOP;
    endcase
  end

  // r_gap forces one NOP cycle between back-to-back init commands so that CMD
  // always drops to NOP after an acknowledge.
  assign w_issuing   = (w_state_cmd != c_CMD_NOP) && !r_gap;
  assign w_ack       = w_issuing && CMDACK;
  assign w_timeout   = w_issuing && !CMDACK && (r_cnt == CW'(ACK_TIMEOUT - 1));
  assign w_req_ready = (r_state == S_IDLE) && r_init_done && !r_ref_pending;
  assign w_accept    = req_valid && w_req_ready;
  assign w_ref_wrap  = (r_ref_cnt == RW'(REF_PERIOD - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = 1'b0;
    if (w_timeout) begin
      w_state_nxt = r_init_done ? S_IDLE : S_WAIT_INIT;
    end else begin
      case (r_state)
        S_WAIT_INIT: if (r_cnt == CW'(INIT_WAIT - 1)) w_state_nxt = S_I_PRE;
        S_I_PRE:     if (w_ack) begin w_state_nxt = S_I_REG2; w_gap_nxt = 1'b1; end
        S_I_REG2:    if (w_ack) begin w_state_nxt = S_I_REG1; w_gap_nxt = 1'b1; end
        S_I_REG1:    if (w_ack) begin w_state_nxt = S_I_MODE; w_gap_nxt = 1'b1; end
        S_I_MODE:    if (w_ack) w_state_nxt = S_IDLE;
        S_IDLE: begin
          if (r_ref_pending)  w_state_nxt = S_REF;
          else if (w_accept)  w_state_nxt = req_write ? S_WR_CMD : S_RD_CMD;
        end
        S_REF:       if (w_ack) w_state_nxt = S_IDLE;
        S_RD_CMD:    if (w_ack) w_state_nxt = (RD_LAT > 1) ? S_RD_WAIT : S_RD_DATA;
        S_RD_WAIT:   if (r_cnt == CW'(RD_LAT - 2)) w_state_nxt = S_RD_DATA;
        S_RD_DATA:   if (r_cnt == CW'(BEATS - 1))  w_state_nxt = S_IDLE;
        S_WR_CMD:    if (w_ack) w_state_nxt = S_WR_DATA;
        S_WR_DATA:   if (r_cnt == CW'(BEATS - 1))  w_state_nxt = S_IDLE;
        default:     w_state_nxt = S_WAIT_INIT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state       <= S_WAIT_INIT;
      r_cnt         <= '0;
      r_gap         <= 1'b0;
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
      r_init_done   <= 1'b0;
      r_err         <= 1'b0;
      r_addr        <= '0;
      r_rd_valid    <= 1'b0;
      r_rd_data     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      // One shared counter: init wait, ack timeout, read latency, beat count.
      if ((w_state_nxt != r_state) || r_gap) r_cnt <= '0;
      else                                   r_cnt <= r_cnt + CW'(1);

      r_ref_cnt <= w_ref_wrap ? '0 : r_ref_cnt + RW'(1);
      // A wrap in the same cycle as the REFRESH acknowledge keeps the request.
      if (w_ref_wrap)                      r_ref_pending <= 1'b1;
      else if ((r_state == S_REF) && w_ack) r_ref_pending <= 1'b0;

      if (w_state_nxt == S_IDLE) r_init_done <= 1'b1;
      if (w_timeout)             r_err       <= 1'b1;
      if (w_accept)              r_addr      <= req_addr;

      r_rd_valid <= (r_state == S_RD_DATA);
      r_rd_data  <= (r_state == S_RD_DATA) ? DATAOUT : '0;
    end
  end

  assign req_ready   = w_req_ready;
  assign CMD         = w_issuing ? w_state_cmd  : c_CMD_NOP;
  assign ADDR        = w_issuing ? w_state_addr : '0;
  assign wd_req      = (r_state == S_WR_DATA);
  assign DATAIN      = wd_req ? wd_data : '0;
  assign DM          = wd_req ? wd_mask : '0;
  assign rd_valid    = r_rd_valid;
  assign rd_data     = r_rd_data;
  assign init_done   = r_init_done;
  assign err_timeout = r_err;
  // Gated with RESET_N so busy reads 0 while reset is held even though the
  // state register sits in WAIT_INIT.
  assign busy        = RESET_N && (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ddr_host_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr_host_cmd_issuer
// Description : Self-checking bench for ddr_host_cmd_issuer. A controller
//               model answers commands with a programmable CMDACK delay and
//               returns read beats; expected commands and beats are queued by
//               the directed stimulus and checked by the monitor.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ddr_host_cmd_issuer;

  localparam int ASIZE  = 23;
  localparam int DSIZE  = 128;
  localparam int RD_LAT = 4;

  localparam logic [127:0] c_RBEAT0 = {16{8'hA5}};
  localparam logic [127:0] c_RBEAT1 = {16{8'h5A}};
  localparam logic [127:0] c_JUNK   = {16{8'h3C}};

  logic               CLK;
  logic               RESET_N;
  logic               req_valid, req_ready, req_write;
  logic [ASIZE-1:0]   req_addr;
  logic               wd_req;
  logic [DSIZE-1:0]   wd_data;
  logic [DSIZE/8-1:0] wd_mask;
  logic               rd_valid;
  logic [DSIZE-1:0]   rd_data;
  logic [ASIZE-1:0]   ADDR;
  logic [2:0]         CMD;
  logic               CMDACK;
  logic [DSIZE-1:0]   DATAIN;
  logic [DSIZE/8-1:0] DM;
  logic [DSIZE-1:0]   DATAOUT;
  logic               init_done, busy, err_timeout;

  ddr_host_cmd_issuer #(
    .ASIZE(ASIZE), .DSIZE(DSIZE), .BEATS(2), .RD_LAT(RD_LAT),
    .INIT_WAIT(200), .REF_PERIOD(1560), .ACK_TIMEOUT(64),
    .MODE_WORD(23'h000033), .REG1_WORD(23'h000011), .REG2_WORD(23'h000022)
  ) u_dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .wd_req(wd_req), .wd_data(wd_data), .wd_mask(wd_mask),
    .rd_valid(rd_valid), .rd_data(rd_data), .ADDR(ADDR), .CMD(CMD),
    .CMDACK(CMDACK), .DATAIN(DATAIN), .DM(DM), .DATAOUT(DATAOUT),
    .init_done(init_done), .busy(busy), .err_timeout(err_timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Rising edges since reset release.
  int ncyc;
  always @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) ncyc <= 0;
    else          ncyc <= ncyc + 1;
  end

  typedef struct packed {
    logic [1:0]   typ;    // 0 command, 1 write beat, 2 read beat
    logic [2:0]   cmd;
    logic [22:0]  addr;
    logic [7:0]   hold;
    logic [127:0] data;
    logic [15:0]  mask;
  } exp_t;

  exp_t         q[$];
  int           n_vec;
  int           n_err;
  int           ack_delay;
  bit           ack_en;
  int           wb_idx;
  logic [127:0] wbeat [2];
  logic [15:0]  wmask [2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] typ, input logic [2:0] cmd, input logic [22:0] addr,
                      input logic [7:0] hold, input logic [127:0] data, input logic [15:0] mask);
    exp_t e;
    e.typ = typ; e.cmd = cmd; e.addr = addr; e.hold = hold; e.data = data; e.mask = mask;
    q.push_back(e);
  endtask

  task automatic push_init();
    push(2'd0, 3'b100, 23'h0,  8'd2, '0, '0);
    push(2'd0, 3'b111, 23'h22, 8'd2, '0, '0);
    push(2'd0, 3'b110, 23'h11, 8'd2, '0, '0);
    push(2'd0, 3'b101, 23'h33, 8'd2, '0, '0);
  endtask

  task automatic pop_exp(input string nm, input logic [1:0] typ, output exp_t e, output bit ok);
    e  = '0;
    ok = 1'b0;
    if (q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: actual unexpected event required none (queue empty)", nm);
    end else begin
      e = q.pop_front();
      chk({nm, "_type"}, typ, e.typ);
      ok = (e.typ == typ);
    end
  endtask

  // Controller model plus output monitor.
  task automatic run_monitor();
    logic [2:0] cur, prev;
    int   age, rd_j, hold_cnt;
    exp_t ce, e;
    bit   ok;
    prev = '0; age = 0; rd_j = -1; hold_cnt = 0; ce = '0;
    forever begin
      @(negedge CLK);
      cur = CMD;
      age = (cur != 3'b000 && prev == cur) ? age + 1 : 0;
      if (rd_j >= 0) rd_j++;
      if (rd_j > 12) rd_j = -1;
      CMDACK = ack_en && (cur != 3'b000) && (age == ack_delay);
      if (CMDACK && cur == 3'b001) rd_j = 0;
      DATAOUT = (rd_j == RD_LAT) ? c_RBEAT0 : (rd_j == RD_LAT + 1) ? c_RBEAT1 : c_JUNK;
      if (wd_req) begin
        wd_data = wbeat[wb_idx];
        wd_mask = wmask[wb_idx];
        wb_idx  = (wb_idx + 1) % 2;
      end else begin
        wd_data = c_JUNK;
        wd_mask = 16'h5A5A;
      end
      #1;
      if (cur != 3'b000 && prev == 3'b000) begin
        pop_exp("cmd", 2'd0, ce, ok);
        if (ok) begin
          chk("cmd_code", CMD, ce.cmd);
          chk("cmd_addr", ADDR, ce.addr);
        end
        hold_cnt = 1;
      end else if (cur != 3'b000) begin
        hold_cnt++;
      end else if (prev != 3'b000) begin
        chk("cmd_hold", hold_cnt, ce.hold);
      end
      if (cur == 3'b000) chk("addr_when_nop", ADDR, '0);
      if (wd_req) begin
        pop_exp("wbeat", 2'd1, e, ok);
        if (ok) begin
          chk("wbeat_datain", DATAIN, e.data);
          chk("wbeat_dm", DM, e.mask);
        end
      end else begin
        chk("datain_idle", {DM, DATAIN}, '0);
      end
      if (rd_valid) begin
        pop_exp("rbeat", 2'd2, e, ok);
        if (ok) chk("rbeat_data", rd_data, e.data);
      end
      prev = cur;
    end
  endtask

  task automatic wait_init();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK); #2;
      if (init_done) begin seen = 1'b1; break; end
    end
    chk("init_done_seen", seen, 1'b1);
    chk("init_done_cycle", ncyc, 211);
  endtask

  task automatic issue(input logic wr, input logic [22:0] addr);
    bit acc;
    acc = 1'b0;
    @(negedge CLK);
    req_valid = 1'b1; req_write = wr; req_addr = addr;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge CLK);
    end
    chk("req_accepted", acc, 1'b1);
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit idle;
    idle = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK); #2;
      if (!busy) begin idle = 1'b1; break; end
    end
    chk("back_to_idle", idle, 1'b1);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_ctl"}, {CMD, ADDR, req_ready, wd_req, rd_valid, busy, init_done, err_timeout}, '0);
    chk({nm, "_data"}, DATAIN | rd_data, '0);
    chk({nm, "_dm"}, DM, '0);
  endtask

  initial begin
    bit seen;
    n_vec = 0; n_err = 0;
    RESET_N = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    CMDACK = 1'b0; DATAOUT = '0; wd_data = '0; wd_mask = '0;
    ack_en = 1'b1; ack_delay = 1; wb_idx = 0;
    wbeat[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210; wmask[0] = 16'h00FF;
    wbeat[1] = 128'hCAFE_F00D_1357_9BDF_2468_ACE0_DEAD_BEEF; wmask[1] = 16'hF0F0;
    fork
      run_monitor();
    join_none

    // Reset and init sequence, CMDACK one cycle after each command.
    repeat (3) @(negedge CLK);
    #2 chk_all_zero("reset");
    push_init();
    @(negedge CLK);
    RESET_N = 1'b1;
    #1 chk("busy_after_release", busy, 1'b1);
    wait_init();
    chk("ready_after_init", req_ready, 1'b1);

    // Write: CMDACK three cycles into the command, two beats.
    ack_delay = 2; wb_idx = 0;
    push(2'd0, 3'b010, 23'h001234, 8'd3, '0, '0);
    push(2'd1, '0, '0, '0, wbeat[0], wmask[0]);
    push(2'd1, '0, '0, '0, wbeat[1], wmask[1]);
    issue(1'b1, 23'h001234);
    wait_idle();

    // Read: immediate CMDACK, beats A5.. then 5A..
    ack_delay = 0;
    push(2'd0, 3'b001, 23'h0ABCDE, 8'd1, '0, '0);
    push(2'd2, '0, '0, '0, c_RBEAT0, '0);
    push(2'd2, '0, '0, '0, c_RBEAT1, '0);
    issue(1'b0, 23'h0ABCDE);
    wait_idle();
    repeat (2) @(negedge CLK);
    #2 chk("err_before_timeout", err_timeout, 1'b0);

    // Timeout: no CMDACK for READA.
    ack_en = 1'b0;
    push(2'd0, 3'b001, 23'h000777, 8'd64, '0, '0);
    issue(1'b0, 23'h000777);
    wait_idle();
    chk("err_timeout_set", err_timeout, 1'b1);
    chk("cmd_nop_after_timeout", CMD, 3'b000);
    ack_en = 1'b1;

    // Refresh wrap coinciding with a request in IDLE.
    for (int i = 0; i < 2000; i++) begin
      @(negedge CLK); #2;
      if (ncyc >= 1559) break;
    end
    chk("ref_wait_cycle", ncyc, 1559);
    chk("ready_before_wrap", req_ready, 1'b1);
    ack_delay = 3;
    push(2'd0, 3'b011, 23'h0, 8'd4, '0, '0);
    push(2'd0, 3'b001, 23'h0000AB, 8'd4, '0, '0);
    push(2'd2, '0, '0, '0, c_RBEAT0, '0);
    push(2'd2, '0, '0, '0, c_RBEAT1, '0);
    @(negedge CLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 23'h0000AB;
    #2 chk("ready_low_on_wrap", req_ready, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK); #2;
      if (req_ready) begin seen = 1'b1; break; end
    end
    chk("ready_after_refresh_seen", seen, 1'b1);
    chk("ready_after_refresh_cycle", ncyc, 1565);
    @(negedge CLK);
    req_valid = 1'b0;
    wait_idle();

    // Reset pulsed during WR_DATA.
    ack_delay = 0; wb_idx = 0;
    push(2'd0, 3'b010, 23'h055555, 8'd1, '0, '0);
    push(2'd1, '0, '0, '0, wbeat[0], wmask[0]);
    issue(1'b1, 23'h055555);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK); #2;
      if (wd_req) begin seen = 1'b1; break; end
    end
    chk("wd_req_before_reset", seen, 1'b1);
    RESET_N = 1'b0;
    #1 chk_all_zero("midwrite_reset");
    push_init();
    ack_delay = 1;
    repeat (2) @(negedge CLK);
    #2 chk_all_zero("reset_held");
    @(negedge CLK);
    RESET_N = 1'b1;
    wait_init();
    chk("err_cleared_by_reset", err_timeout, 1'b0);

    repeat (5) @(negedge CLK);
    chk("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
